pipe_stall_ctrl: RTL and testbench

//  Drives the en/clear inputs of the five pipeline registers (F,D,E,M,W) in the MIPS core.

---
 rtl/pipe_stall_ctrl_pkg.sv | 33 +++
 rtl/pipe_stall_ctrl_if.sv | 40 ++++
 rtl/pipe_stall_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stage vectors are indexed F=0 .. W=4.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int NSTAGE = 5;
    localparam int STG_F  = 0;
    localparam int STG_D  = 1;
    localparam int STG_E  = 2;
    localparam int STG_M  = 3;
    localparam int STG_W  = 4;

    typedef logic [NSTAGE-1:0] stg_vec_t;

    localparam stg_vec_t EN_NONE = 5'b00000;
    localparam stg_vec_t EN_ALL  = 5'b11111;
    localparam stg_vec_t EN_MEM  = 5'b10000;
    localparam stg_vec_t EN_DIV  = 5'b11000;
    localparam stg_vec_t EN_LW   = 5'b11100;

    localparam stg_vec_t CLR_NONE = 5'b00000;
    localparam stg_vec_t CLR_MEM  = 5'b10000;
    localparam stg_vec_t CLR_EXC  = 5'b11110;
    localparam stg_vec_t CLR_DIV  = 5'b01000;
    localparam stg_vec_t CLR_LW   = 5'b00100;
    localparam stg_vec_t CLR_BR   = 5'b00010;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-source inputs and per-stage enable/clear outputs of the
// stall controller, bundled for the core top and for test harnesses.
interface pipe_stall_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             lw_stall;
    logic             br_flush;
    logic             div_start;
    logic             div_ready;
    logic             mem_req;
    logic             mem_ready;
    logic             exc_flush;
    logic             cnt_clr;
    stg_vec_t         stage_en;
    stg_vec_t         stage_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic             busy;

    modport master (
        output lw_stall, br_flush,
        output div_start, div_ready,
        output mem_req, mem_ready,
        output exc_flush, cnt_clr,
        input  stage_en, stage_clr,
        input  stall_cnt, busy
    );

    modport slave (
        input  lw_stall, br_flush,
        input  div_start, div_ready,
        input  mem_req, mem_ready,
        input  exc_flush, cnt_clr,
        output stage_en, stage_clr,
        output stall_cnt, busy
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter for performance events.
// Clear has priority over increment; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Merges load-use, branch, divider, data-memory and exception hazards
// into per-stage enable/clear vectors and counts front-end stall cycles.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_stall_ctrl_if.slave  bus
);

    state_t   state;
    logic     flush_pend;
    logic     busy_q;
    logic     mem_hold;
    logic     div_hold;
    logic     flush;
    stg_vec_t en;
    stg_vec_t clr;

    // A wait state releases in the ready cycle itself, so the hold
    // terms already drop while state still shows the wait.
    always_comb begin
        mem_hold = 1'b0;
        div_hold = 1'b0;
        unique case (state)
            MEM_WAIT: mem_hold = !bus.mem_ready;
            DIV_WAIT: div_hold = !bus.div_ready;
            default: begin
                mem_hold = bus.mem_req & !bus.mem_ready;
                div_hold = bus.div_start & !bus.div_ready;
            end
        endcase
        flush = bus.exc_flush
              | ((state == MEM_WAIT) & flush_pend);
    end

    always_comb begin
        en  = EN_ALL;
        clr = CLR_NONE;
        priority case (1'b1)
            rst: begin
                en  = EN_NONE;
                clr = CLR_NONE;
            end
            mem_hold: begin
                en  = EN_MEM;
                clr = CLR_MEM;
            end
            flush: begin
                en  = EN_ALL;
                clr = CLR_EXC;
            end
            div_hold: begin
                en  = EN_DIV;
                clr = CLR_DIV;
            end
            bus.lw_stall: begin
                en  = EN_LW;
                clr = CLR_LW;
            end
            bus.br_flush: begin
                en  = EN_ALL;
                clr = CLR_BR;
            end
            default: begin
                en  = EN_ALL;
                clr = CLR_NONE;
            end
        endcase
    end

    // An exception under a memory stall is parked in flush_pend and
    // applied in the cycle the access completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        state      <= MEM_WAIT;
                        flush_pend <= bus.exc_flush;
                        busy_q     <= 1'b1;
                    end else if (!bus.exc_flush
                                 && bus.div_start
                                 && !bus.div_ready) begin
                        state  <= DIV_WAIT;
                        busy_q <= 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (bus.div_ready || bus.exc_flush) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state      <= RUN;
                        flush_pend <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (bus.exc_flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_pend <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (!en[STG_F]),
        .q   (bus.stall_cnt)
    );

    assign bus.stage_en  = en;
    assign bus.stage_clr = clr;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized checks of pipe_stall_ctrl against a
// rule-level reference model of the stall/flush behaviour.
module tb_pipe_stall_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the pipeline is waiting on, and whether
    // an exception is parked behind a memory stall.
    bit m_mem  = 0;
    bit m_div  = 0;
    bit m_pend = 0;
    int m_cnt  = 0;

    task automatic drive(input bit r, input bit lw, input bit br,
                         input bit ds, input bit dr, input bit mq,
                         input bit mr, input bit ex, input bit cc);
        rst           = r;
        bus.lw_stall  = lw;
        bus.br_flush  = br;
        bus.div_start = ds;
        bus.div_ready = dr;
        bus.mem_req   = mq;
        bus.mem_ready = mr;
        bus.exc_flush = ex;
        bus.cnt_clr   = cc;
    endtask

    function automatic void exp_out(output logic [4:0] en,
                                    output logic [4:0] clr);
        bit ms, ds, fl;
        if (rst) begin
            en = 5'b00000; clr = 5'b00000;
            return;
        end
        ms = m_mem ? !bus.mem_ready
                   : (!m_div && bus.mem_req && !bus.mem_ready);
        fl = bus.exc_flush || (m_mem && m_pend);
        ds = m_div ? !bus.div_ready
                   : (!m_mem && bus.div_start && !bus.div_ready);
        if (ms) begin
            en = 5'b10000; clr = 5'b10000;
        end else if (fl) begin
            en = 5'b11111; clr = 5'b11110;
        end else if (ds) begin
            en = 5'b11000; clr = 5'b01000;
        end else if (bus.lw_stall) begin
            en = 5'b11100; clr = 5'b00100;
        end else if (bus.br_flush) begin
            en = 5'b11111; clr = 5'b00010;
        end else begin
            en = 5'b11111; clr = 5'b00000;
        end
    endfunction

    // Advance the model by one clock using the current inputs.
    task automatic step();
        logic [4:0] en, clr;
        exp_out(en, clr);
        if (rst) begin
            m_mem = 0; m_div = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (bus.cnt_clr) m_cnt = 0;
            else if (!en[0] && m_cnt < CMAX) m_cnt++;
            if (m_mem) begin
                if (bus.mem_ready) begin
                    m_mem = 0; m_pend = 0;
                end else if (bus.exc_flush) begin
                    m_pend = 1;
                end
            end else if (m_div) begin
                if (bus.div_ready || bus.exc_flush) m_div = 0;
            end else if (bus.mem_req && !bus.mem_ready) begin
                m_mem = 1; m_pend = bus.exc_flush;
            end else if (!bus.exc_flush && bus.div_start
                         && !bus.div_ready) begin
                m_div = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stage_en !== 5'b00000) begin
                errors++;
                $display("FAIL rst_en got %b want 00000", bus.stage_en);
            end
            checks++;
            if (bus.stage_clr !== 5'b00000) begin
                errors++;
                $display("FAIL rst_clr got %b want 00000", bus.stage_clr);
            end
            if (i == 1) begin
                checks++;
                if (bus.stall_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL rst_cnt got %0d want 0", bus.stall_cnt);
                end
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_busy got %b want 0", bus.busy);
                end
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stage_en !== 5'b11111) begin
            errors++;
            $display("FAIL rel_en got %b want 11111", bus.stage_en);
        end
        step();
    endtask

    task automatic test_lw_stall();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stage_en !== 5'b11100 || bus.stage_clr !== 5'b00100) begin
            errors++;
            $display("FAIL lw en/clr got %b/%b want 11100/00100",
                     bus.stage_en, bus.stage_clr);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lw_cnt got %0d want 1", bus.stall_cnt);
        end
        step();
    endtask

    task automatic test_div();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, i == 0, i == 4, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (i < 4) begin
                if (bus.stage_en !== 5'b11000
                    || bus.stage_clr !== 5'b01000) begin
                    errors++;
                    $display("FAIL div_wait%0d got %b/%b want 11000/01000",
                             i, bus.stage_en, bus.stage_clr);
                end
            end else if (bus.stage_en !== 5'b11111
                         || bus.stage_clr !== 5'b00000) begin
                errors++;
                $display("FAIL div_rel got %b/%b want 11111/00000",
                         bus.stage_en, bus.stage_clr);
            end
            if (i > 0) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL div_busy%0d got %b want 1", i, bus.busy);
                end
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.stall_cnt !== 4'd5) begin
            errors++;
            $display("FAIL div_after busy/cnt got %b/%0d want 0/5",
                     bus.busy, bus.stall_cnt);
        end
        step();
    endtask

    task automatic test_mem_exc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, i == 3, i == 0, 0);
            @(negedge clk);
            checks++;
            if (i < 3) begin
                if (bus.stage_en !== 5'b10000
                    || bus.stage_clr !== 5'b10000) begin
                    errors++;
                    $display("FAIL mem_wait%0d got %b/%b want 10000/10000",
                             i, bus.stage_en, bus.stage_clr);
                end
            end else if (bus.stage_en !== 5'b11111
                         || bus.stage_clr !== 5'b11110) begin
                errors++;
                $display("FAIL mem_exc_rel got %b/%b want 11111/11110",
                         bus.stage_en, bus.stage_clr);
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stage_clr !== 5'b00000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mem_after clr/busy got %b/%b want 00000/0",
                     bus.stage_clr, bus.busy);
        end
        step();
        // A second stall with no exception must release cleanly.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stage_en !== 5'b11111 || bus.stage_clr !== 5'b00000) begin
            errors++;
            $display("FAIL mem_noleak got %b/%b want 11111/00000",
                     bus.stage_en, bus.stage_clr);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== 4'd9) begin
            errors++;
            $display("FAIL mem_cnt got %0d want 9", bus.stall_cnt);
        end
        step();
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (20) step();
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_cnt got %h want f", bus.stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== 4'h0) begin
            errors++;
            $display("FAIL sat_clr got %h want 0", bus.stall_cnt);
        end
        step();
    endtask

    task automatic test_div_exc();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (bus.stage_en !== 5'b11111 || bus.stage_clr !== 5'b11110) begin
            errors++;
            $display("FAIL div_exc got %b/%b want 11111/11110",
                     bus.stage_en, bus.stage_clr);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.stage_en !== 5'b11111) begin
            errors++;
            $display("FAIL div_exc_after busy/en got %b/%b want 0/11111",
                     bus.busy, bus.stage_en);
        end
        step();
    endtask

    task automatic test_rst_mid_div();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.stage_en !== 5'b11111) begin
                errors++;
                $display("FAIL rst_div%0d busy/en got %b/%b want 0/11111",
                         i, bus.busy, bus.stage_en);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [4:0] en, clr;
        bit idle;
        for (int i = 0; i < 800; i++) begin
            idle = !m_mem && !m_div;
            drive($urandom_range(99) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(5) == 0,
                  idle && $urandom_range(5) == 0,
                  $urandom_range(2) == 0,
                  idle && $urandom_range(5) == 0,
                  $urandom_range(2) == 0,
                  $urandom_range(9) == 0,
                  $urandom_range(19) == 0);
            @(negedge clk);
            exp_out(en, clr);
            checks++;
            if (bus.stage_en !== en || bus.stage_clr !== clr) begin
                errors++;
                $display("FAIL rnd%0d en/clr got %b/%b want %b/%b",
                         i, bus.stage_en, bus.stage_clr, en, clr);
            end
            checks++;
            if (bus.stall_cnt !== CNT_W'(m_cnt)
                || bus.busy !== (m_mem | m_div)) begin
                errors++;
                $display("FAIL rnd%0d cnt/busy got %0d/%b want %0d/%b",
                         i, bus.stall_cnt, bus.busy, m_cnt, m_mem | m_div);
            end
            step();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_lw_stall();
        test_div();
        test_mem_exc();
        test_saturation();
        test_div_exc();
        test_rst_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
